// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// The master modport is the control FSM; the slave modport is the datapath side.
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       ExtOp;
    logic [1:0] PCSrc;
    logic       Illegal;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, Illegal
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSrc, Illegal
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore decode of datapath enables/selects from the state register,
// with FETCH write enables qualified by memory ready and BRANCH PC write by the ALU zero flag.
module mips_multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    mips_multicycle_control_if.master   bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   is_sw_q, is_sw_d;   // LW/SW choice captured in DECODE so MEMADR ignores later opcode changes
    logic   ext_q, ext_d;       // ExtOp captured in IEXEC and replayed in IWB
    logic   mem_rdy_s;
    logic   logical_s;

    assign mem_rdy_s = MEM_HANDSHAKE ? bus.MemReady : 1'b1;
    assign logical_s = (bus.Opcode == OP_ANDI) || (bus.Opcode == OP_ORI);

    // State and captured-decode registers with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            is_sw_q <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
            ext_q   <= ext_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d      = S_FETCH;
        is_sw_d      = is_sw_q;
        ext_d        = ext_q;
        bus.PCWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.ExtOp    = 1'b0;
        bus.PCSrc    = 2'b00;
        bus.Illegal  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = mem_rdy_s;
                bus.PCWrite = mem_rdy_s;
                if (mem_rdy_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                is_sw_d     = (bus.Opcode == OP_SW);
                case (bus.Opcode)
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_R:                      state_d = S_REXEC;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
                    OP_J:                      state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        bus.Illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
                if (is_sw_q) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (mem_rdy_s) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (mem_rdy_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_REXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = logical_s ? 2'b11 : 2'b00;
                bus.ExtOp   = ~logical_s;
                ext_d       = ~logical_s;
                state_d     = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                bus.ExtOp    = ext_q;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b01;
                bus.PCSrc   = 2'b01;
                bus.PCWrite = bus.Zero;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: per-instruction expected cycle sequences built from the control table.
module tb_mips_multicycle_control;
    typedef logic [16:0] vec_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: PCWrite IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp ExtOp PCSrc Illegal
    function automatic vec_t mk(input logic pcw, input logic iord, input logic mrd, input logic mwr,
                                input logic irw, input logic rdst, input logic m2r, input logic rw,
                                input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                input logic ext, input logic [1:0] pcs, input logic ill);
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, ext, pcs, ill};
    endfunction

    function automatic vec_t e_zero();           return '0; endfunction
    function automatic vec_t e_fetch(logic r);   return mk(r,1'b0,1'b1,1'b0,r,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_decode(logic il); return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1,2'b00,il); endfunction
    function automatic vec_t e_memadr();         return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b1,2'b00,1'b0); endfunction
    function automatic vec_t e_memrd();          return mk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_memwb();          return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_memwr();          return mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_rexec();          return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_rwb();            return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0); endfunction
    function automatic vec_t e_iexec(logic lg);  return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,(lg ? 2'b11 : 2'b00),~lg,2'b00,1'b0); endfunction
    function automatic vec_t e_iwb(logic lg);    return mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,~lg,2'b00,1'b0); endfunction
    function automatic vec_t e_branch(logic z);  return mk(z,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b01,1'b0); endfunction
    function automatic vec_t e_jump();           return mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b10,1'b0); endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_J);
    endfunction

    // One clock cycle: drive inputs after the edge, check outputs at the falling edge
    task automatic step(input vec_t exp, input logic mr, input logic z, input logic [5:0] op, input string tag);
        vec_t got;
        int   n_wr;
        bus.MemReady = mr;
        bus.Zero     = z;
        bus.Opcode   = op;
        @(negedge clk);
        got = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
               bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ExtOp,
               bus.PCSrc, bus.Illegal};
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", tag, got, exp);
        end
        n_wr = int'(bus.PCWrite) + int'(bus.RegWrite) + int'(bus.MemWrite);
        n_cmp++;
        assert (n_wr <= 1) else begin
            n_err++;
            $error("FAIL %s_excl: observed %0d write enables expected at most 1", tag, n_wr);
        end
        @(posedge clk);
        #1;
    endtask

    // Full instruction from FETCH back to the next FETCH, with fetch/memory wait counts
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        logic lg;
        lg = (op == OP_ANDI) || (op == OP_ORI);
        for (int i = 0; i < fw; i++) step(e_fetch(1'b0), 1'b0, rnd_bit(), rnd_op(), "fetch_wait");
        step(e_fetch(1'b1), 1'b1, rnd_bit(), op, "fetch");
        step(e_decode(~is_known(op)), rnd_bit(), rnd_bit(), op, "decode");
        case (op)
            OP_LW: begin
                step(e_memadr(), rnd_bit(), rnd_bit(), rnd_op(), "lw_memadr");
                for (int i = 0; i < mw; i++) step(e_memrd(), 1'b0, rnd_bit(), rnd_op(), "memrd_wait");
                step(e_memrd(), 1'b1, rnd_bit(), rnd_op(), "memrd");
                step(e_memwb(), rnd_bit(), rnd_bit(), rnd_op(), "memwb");
            end
            OP_SW: begin
                step(e_memadr(), rnd_bit(), rnd_bit(), rnd_op(), "sw_memadr");
                for (int i = 0; i < mw; i++) step(e_memwr(), 1'b0, rnd_bit(), rnd_op(), "memwr_wait");
                step(e_memwr(), 1'b1, rnd_bit(), rnd_op(), "memwr");
            end
            OP_R: begin
                step(e_rexec(), rnd_bit(), rnd_bit(), rnd_op(), "rexec");
                step(e_rwb(), rnd_bit(), rnd_bit(), rnd_op(), "rwb");
            end
            OP_BEQ: begin
                step(e_branch(z), rnd_bit(), z, rnd_op(), "branch");
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                step(e_iexec(lg), rnd_bit(), rnd_bit(), op, "iexec");
                step(e_iwb(lg), rnd_bit(), rnd_bit(), rnd_op(), "iwb");
            end
            OP_J: begin
                step(e_jump(), rnd_bit(), rnd_bit(), rnd_op(), "jump");
            end
            default: begin
            end
        endcase
    endtask

    initial begin
        logic [5:0] ops [0:9];
        logic [5:0] op;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.Opcode   = 6'b000000;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;
        ops[0] = OP_R;   ops[1] = OP_LW;   ops[2] = OP_SW;   ops[3] = OP_BEQ;  ops[4] = OP_ADDI;
        ops[5] = OP_ANDI; ops[6] = OP_ORI; ops[7] = OP_J;    ops[8] = 6'b111111; ops[9] = 6'b010101;
        @(posedge clk);
        #1;

        // Reset held for two cycles, then one IDLE cycle before FETCH
        step(e_zero(), rnd_bit(), rnd_bit(), rnd_op(), "reset0");
        step(e_zero(), rnd_bit(), rnd_bit(), rnd_op(), "reset1");
        rst_n = 1'b1;
        step(e_zero(), rnd_bit(), rnd_bit(), rnd_op(), "idle");

        // Directed cases from the control table
        run_instr(OP_LW,   0, 0, 1'b0);
        run_instr(OP_SW,   0, 3, 1'b0);
        run_instr(OP_ANDI, 0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(OP_BEQ,  0, 0, 1'b1);
        run_instr(OP_BEQ,  0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(OP_ORI,  1, 0, 1'b0);
        run_instr(OP_R,    0, 0, 1'b0);
        run_instr(OP_J,    0, 0, 1'b0);

        // Reset during a MEMRD wait forces IDLE on that edge
        step(e_fetch(1'b1), 1'b1, 1'b0, OP_LW, "rst_fetch");
        step(e_decode(1'b0), 1'b0, 1'b0, OP_LW, "rst_decode");
        step(e_memadr(), 1'b0, 1'b0, OP_LW, "rst_memadr");
        step(e_memrd(), 1'b0, 1'b0, OP_LW, "rst_memrd_wait");
        rst_n = 1'b0;
        step(e_memrd(), 1'b0, 1'b0, OP_LW, "rst_memrd_edge");
        step(e_zero(), 1'b1, 1'b0, OP_LW, "rst_idle_held");
        rst_n = 1'b1;
        step(e_zero(), 1'b1, 1'b0, OP_LW, "rst_idle");

        // Randomized instruction stream with random waits and Zero
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 9)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rnd_bit());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
